seg7_scan_bcd_driver: RTL
=========================

// Module: seg7_scan_bcd_driver
// PURPOSE
//   Four-digit, common-anode seven-segment display driver for the ultrasonic range display.
//   Sits directly downstream of the display clock divider and consumes its CLKOUTseg square wave as the digit-scan rate.
//   Accepts a binary distance value on a load strobe and converts it to BCD with a sequential double-dabble engine.
//   Scans the four digits, one per CLKOUTseg rising edge.
// PARAMETERS
//   BLANK_LZ  1'b1  1: leading-zero digits blanked (segments off); 0: all four digits shown
//   MAX_VAL   9999  saturation limit; any value_in above it is displayed as MAX_VAL
// PORTS
//   clk        in   1   system clock (100 MHz); same clock that drives the divider
//   reset      in   1   synchronous, active-high reset
//   CLKOUTseg  in   1   scan-rate square wave from the divider, synchronous to clk
//   value_in   in   14  binary value to display (0..16383, saturated to MAX_VAL)
//   load       in   1   1-cycle strobe: capture value_in and start conversion
//   busy       out  1   high while a conversion is in progress
//   an         out  4   digit enables, active-low; an[0] = units digit
//   seg        out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp         out  1   decimal point, active-low; held 1 (off)
// BEHAVIOUR
//   Reset (clk edge with reset=1): every output and every state element is initialised.
//     - Outputs: an=4'b1111, seg=7'b1111111, dp=1, busy=0.
//     - State: FSM=IDLE, digit index=0, displayed digits=0, CLKOUTseg history reg=1.
//     - Reset has priority over all else. Reset during SHIFT aborts the conversion; no partial result is kept.
//   Scan tick: tick = CLKOUTseg & ~CLKOUTseg_q (rising edge only).
//     - CLKOUTseg_q is registered every clk.
//     - On tick, digit index advances 0->1->2->3->0 (2-bit wrap).
//     - With divider top=T, one tick every 2*(T+1) clk cycles.
//   an/seg are registered from the current digit index and the displayed-digit regs, giving 1-cycle latency.
//     - an = ~(4'b0001 << idx).
//     - A blanked digit keeps its an active but drives seg=7'b1111111.
//   Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000,
//     8=0000000, 9=0010000.
//   Leading-zero rule (BLANK_LZ=1):
//     - digit k is blanked if it and every higher digit are 0, for k=3..1.
//     - Digit 0 is never blanked, so value 0 shows "0".
//   Conversion FSM:
//     - IDLE:
//       - On load: capture min(value_in, MAX_VAL) into shift reg, clear the 16-bit BCD accumulator,
//         clear iter, go to SHIFT.
//       - busy=1 from the next cycle.
//     - SHIFT:
//       - Each clk: add 3 to every BCD nibble >=5, then shift {bcd, bin} left 1.
//       - iter++ each clk; after 14 shifts (iter==13) go to DONE.
//     - DONE:
//       - Copy the BCD accumulator into the displayed-digit regs in one cycle (all four digits atomically),
//         then go to IDLE.
//       - busy=0 from the next cycle.
//   Latency: load sampled at cycle n -> busy high cycles n+1..n+15 -> displayed digits valid at n+16 ->
//     seg reflects them at n+17.
//   load while busy is ignored; the value is not queued.
//   load in the same cycle busy falls is accepted (the FSM is in IDLE).
//   Tick coinciding with DONE: the scan advances normally. The new digits appear on seg from the following cycle;
//     there is no glitch and no mixing of old and new digits within one digit slot.
//   Displayed value persists indefinitely until the next completed conversion.
// TESTING
//   1. Reset then idle: an=1111, seg=1111111, dp=1, busy=0.
//      After the first tick: an=1110, seg=1000000 ("0").
//   2. load value_in=1234:
//      - busy high exactly 15 cycles.
//      - Over 4 ticks, digits 0..3 show 4,3,2,1 (seg 0011001, 0110000, 0100100, 1111001).
//   3. value_in=7, BLANK_LZ=1: digit0=1111000, digits 1..3 blanked.
//      Rerun with BLANK_LZ=0: digits 1..3 show 1000000.
//   4. value_in=16383: saturates, all digits show 9 (0010000).
//      Then value_in=9999 gives an identical display.
//   5. load 5678, second load 42 at n+5: 42 is ignored and busy timing is unchanged, display shows 5678.
//      Then assert reset at a SHIFT cycle of a new load: display clears to "0", busy=0.
//   6. Short divider (T=3): verify a tick every 8 clk, an walks 1110->1101->1011->0111->1110,
//      and seg changes exactly 1 cycle after each tick.

Source files
------------

// File: rtl/seg7_scan_bcd_driver_if.sv
// seg7_scan_bcd_driver_if: scan strobe, value load and display pins of the 7-segment driver
interface seg7_scan_bcd_driver_if;
  logic CLKOUTseg;
  logic [13:0] value_in;
  logic load;
  logic busy;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp;
  modport master (output CLKOUTseg, value_in, load, input busy, an, seg, dp);
  modport slave (input CLKOUTseg, value_in, load, output busy, an, seg, dp);
endinterface

// File: rtl/seg7_scan_bcd_driver.sv
// seg7_scan_bcd_driver: 4-digit common-anode scan driver with sequential binary-to-BCD conversion
module seg7_scan_bcd_driver #(
  parameter logic BLANK_LZ = 1'b1,
  parameter int MAX_VAL = 9999
) (
  input logic clk,
  input logic reset,
  seg7_scan_bcd_driver_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic clk_q, started, tick;
  logic [1:0] idx;
  logic [3:0] iter, cur, blank;
  logic [13:0] bin, sat;
  logic [15:0] bcd, adj, disp;
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: dec = 7'b1000000;
      4'd1: dec = 7'b1111001;
      4'd2: dec = 7'b0100100;
      4'd3: dec = 7'b0110000;
      4'd4: dec = 7'b0011001;
      4'd5: dec = 7'b0010010;
      4'd6: dec = 7'b0000010;
      4'd7: dec = 7'b1111000;
      4'd8: dec = 7'b0000000;
      4'd9: dec = 7'b0010000;
      default: dec = 7'b1111111;
    endcase
  endfunction
  always_comb begin
    tick = bus.CLKOUTseg & ~clk_q;
    sat = (bus.value_in > 14'(MAX_VAL)) ? 14'(MAX_VAL) : bus.value_in;
    cur = disp[{idx, 2'b00} +: 4];
    blank = BLANK_LZ ? {disp[15:12] == 4'd0,
                        disp[15:8] == 8'd0,
                        disp[15:4] == 12'd0,
                        1'b0} : 4'b0000;
    adj = bcd;
    for (int i = 0; i < 4; i++)
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  // The first tick after reset only enables the scan so digit 0 is shown first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      clk_q <= 1'b1;
      started <= 1'b0;
      idx <= 2'd0;
      iter <= 4'd0;
      bin <= 14'd0;
      bcd <= 16'd0;
      disp <= 16'd0;
      busy_clr: bus.busy <= 1'b0;
      bus.an <= 4'b1111;
      bus.seg <= 7'b1111111;
      bus.dp <= 1'b1;
    end else begin
      clk_q <= bus.CLKOUTseg;
      if (tick) begin
        started <= 1'b1;
        if (started) idx <= idx + 2'd1;
      end
      bus.an <= started ? ~(4'b0001 << idx) : 4'b1111;
      bus.seg <= (started && !blank[idx]) ? dec(cur) : 7'b1111111;
      bus.dp <= 1'b1;
      case (state)
        IDLE: if (bus.load) begin
          bin <= sat;
          bcd <= 16'd0;
          iter <= 4'd0;
          bus.busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, bin} <= {adj, bin} << 1;
          iter <= iter + 4'd1;
          if (iter == 4'd13) state <= DONE;
        end
        DONE: begin
          disp <= bcd;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
